// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
package wb_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   // One queued writeback: destination register and result.
   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback requests, with a per-slot
// valid/rd view so the owner can search queued destinations for hazards.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  wb_req_t                        push_req,
   input  logic                           pop,
   output wb_req_t                        head,
   output logic                           full,
   output logic                           empty,
   output logic [DEPTH-1:0]               entry_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]   entry_rd
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   wb_req_t            mem [DEPTH];
   logic [DEPTH-1:0]   valid;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   // Pointers coincide only when empty or full; the slot's valid bit tells which.
   assign full        = valid[wr_ptr];
   assign empty       = !valid[rd_ptr];
   assign head        = mem[rd_ptr];
   assign entry_valid = valid;

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (pop && !empty) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Payload storage needs no reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr] <= push_req;
      end
   end

   // Destination view of every slot for the hazard compare.
   always_comb begin
      entry_rd = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         entry_rd[i] = mem[i].rd;
      end
   end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Serialises writebacks from the ALU (A) and load unit (B) onto the single
// register-file write port, round-robin, and flags registers with writes pending.
module regfile_writeback_arbiter
   import wb_pkg::wb_req_t;
   import wb_pkg::grant_t;
   import wb_pkg::GRANT_A;
   import wb_pkg::GRANT_B;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] query_reg_1,
   input  logic [ADDR_W-1:0] query_reg_2,
   output logic              pending_1,
   output logic              pending_2
);

   wb_req_t                      a_req, b_req, a_head, b_head;
   logic                         a_push, b_push, a_full, b_full, a_empty, b_empty;
   logic                         grant_a, grant_b;
   logic [DEPTH-1:0]             a_entry_valid, b_entry_valid;
   logic [DEPTH-1:0][ADDR_W-1:0] a_entry_rd, b_entry_rd;
   grant_t                       last_grant;

   // Ready reflects only FIFO fullness; writes to x0 are accepted but dropped.
   assign a_ready = !rst && !a_full;
   assign b_ready = !rst && !b_full;
   assign a_push  = a_valid && a_ready && (a_rd != '0);
   assign b_push  = b_valid && b_ready && (b_rd != '0);
   assign a_req   = '{rd: a_rd, data: a_data};
   assign b_req   = '{rd: b_rd, data: b_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk         (clk),
      .rst         (rst),
      .push        (a_push),
      .push_req    (a_req),
      .pop         (grant_a),
      .head        (a_head),
      .full        (a_full),
      .empty       (a_empty),
      .entry_valid (a_entry_valid),
      .entry_rd    (a_entry_rd)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk         (clk),
      .rst         (rst),
      .push        (b_push),
      .push_req    (b_req),
      .pop         (grant_b),
      .head        (b_head),
      .full        (b_full),
      .empty       (b_empty),
      .entry_valid (b_entry_valid),
      .entry_rd    (b_entry_rd)
   );

   // Round-robin grant: under contention, the source not granted last wins.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!a_empty && (b_empty || last_grant == GRANT_B)) begin
         grant_a = 1'b1;
      end else if (!b_empty) begin
         grant_b = 1'b1;
      end
   end

   // Registered write port and grant history.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_en   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         last_grant <= GRANT_B;
      end else if (grant_a) begin
         write_en   <= 1'b1;
         write_reg  <= a_head.rd;
         write_data <= a_head.data;
         last_grant <= GRANT_A;
      end else if (grant_b) begin
         write_en   <= 1'b1;
         write_reg  <= b_head.rd;
         write_data <= b_head.data;
         last_grant <= GRANT_B;
      end else begin
         write_en   <= 1'b0;
      end
   end

   // Hazard lookup over both queues and the output register; x0 never pends.
   always_comb begin
      pending_1 = write_en && (write_reg == query_reg_1);
      pending_2 = write_en && (write_reg == query_reg_2);
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (a_entry_valid[i] && a_entry_rd[i] == query_reg_1) pending_1 = 1'b1;
         if (b_entry_valid[i] && b_entry_rd[i] == query_reg_1) pending_1 = 1'b1;
         if (a_entry_valid[i] && a_entry_rd[i] == query_reg_2) pending_2 = 1'b1;
         if (b_entry_valid[i] && b_entry_rd[i] == query_reg_2) pending_2 = 1'b1;
      end
      if (query_reg_1 == '0) pending_1 = 1'b0;
      if (query_reg_2 == '0) pending_2 = 1'b0;
   end

endmodule
